// File: rtl/core_mgmt_write_arbiter.sv
// core_mgmt_write_arbiter: round-robin arbiter sharing one AXI-lite write path between per-core mailbox writers.
// Out-of-window requests are rejected locally and never reach AXI.
module core_mgmt_write_arbiter #(
   parameter int                NUM_REQ  = 2,
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] WIN_BASE = 32'h6000_0000,
   parameter logic [ADDR_W-1:0] WIN_SIZE = 32'h0000_1000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic [NUM_REQ*DATA_W/8-1:0] req_strb,
   output logic [NUM_REQ-1:0]          resp_valid,
   output logic [NUM_REQ-1:0]          resp_err,
   output logic                        busy,
   output logic                        m_awvalid,
   input  logic                        m_awready,
   output logic [ADDR_W-1:0]           m_awaddr,
   output logic                        m_wvalid,
   input  logic                        m_wready,
   output logic [DATA_W-1:0]           m_wdata,
   output logic [DATA_W/8-1:0]         m_wstrb,
   input  logic                        m_bvalid,
   output logic                        m_bready,
   input  logic [1:0]                  m_bresp
);
   localparam int STRB_W = DATA_W/8;
   localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, REJECT, XFER, RESP} state_t;

   state_t              state, state_n;
   logic [IW-1:0]       rr_ptr, g, scan, own, own_nxt;
   logic                g_vld, legal, accept, aw_done, w_done, aw_fin, w_fin;
   logic [ADDR_W-1:0]   sel_addr;
   logic [ADDR_W:0]     win_lo, win_hi;
   logic [NUM_REQ-1:0]  own_oh;

   // Lowest scan offset from rr_ptr wins, so iterate downward and let the last hit stand.
   always_comb begin
      g     = '0;
      g_vld = 1'b0;
      scan  = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         scan = IW'((int'(rr_ptr) + k) % NUM_REQ);
         if (req_valid[scan]) begin
            g     = scan;
            g_vld = 1'b1;
         end
      end
   end

   assign accept    = (state == IDLE) && g_vld;
   assign req_ready = accept ? NUM_REQ'(1) << g : '0;
   assign sel_addr  = req_addr[g*ADDR_W +: ADDR_W];
   assign win_lo    = {1'b0, WIN_BASE};
   assign win_hi    = win_lo + {1'b0, WIN_SIZE};
   assign legal     = ({1'b0, sel_addr} >= win_lo) && ({1'b0, sel_addr} < win_hi);
   assign aw_fin    = aw_done | (m_awvalid & m_awready);
   assign w_fin     = w_done | (m_wvalid & m_wready);
   assign own_nxt   = (own == IW'(NUM_REQ-1)) ? '0 : own + 1'b1;
   assign own_oh    = NUM_REQ'(1) << own;
   assign busy      = state != IDLE;

   always_comb begin
      state_n = (state == IDLE)   ? (accept ? (legal ? XFER : REJECT) : IDLE) :
                (state == REJECT) ? IDLE :
                (state == XFER)   ? ((aw_fin && w_fin) ? RESP : XFER) :
                                    (m_bvalid ? IDLE : RESP);
   end

   always_ff @(posedge clk)
      state <= rst ? IDLE : state_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr     <= '0;
         own        <= '0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         m_awvalid  <= 1'b0;
         m_wvalid   <= 1'b0;
         m_bready   <= 1'b0;
         m_awaddr   <= '0;
         m_wdata    <= '0;
         m_wstrb    <= '0;
         resp_valid <= '0;
         resp_err   <= '0;
      end else begin
         resp_valid <= '0;
         resp_err   <= '0;
         if (accept) begin
            own <= g;
            if (legal) begin
               m_awaddr  <= sel_addr;
               m_wdata   <= req_data[g*DATA_W +: DATA_W];
               m_wstrb   <= req_strb[g*STRB_W +: STRB_W];
               m_awvalid <= 1'b1;
               m_wvalid  <= 1'b1;
            end else begin
               resp_valid <= NUM_REQ'(1) << g;
               resp_err   <= NUM_REQ'(1) << g;
            end
         end
         if (state == REJECT)
            rr_ptr <= own_nxt;
         if (state == XFER) begin
            if (m_awvalid && m_awready) begin
               m_awvalid <= 1'b0;
               aw_done   <= 1'b1;
            end
            if (m_wvalid && m_wready) begin
               m_wvalid <= 1'b0;
               w_done   <= 1'b1;
            end
            if (aw_fin && w_fin) begin
               aw_done  <= 1'b0;
               w_done   <= 1'b0;
               m_bready <= 1'b1;
            end
         end
         // SLVERR (10) and DECERR (11) both flag an error.
         if (m_bready && m_bvalid) begin
            m_bready   <= 1'b0;
            resp_valid <= own_oh;
            resp_err   <= (m_bresp >= 2'b10) ? own_oh : '0;
            rr_ptr     <= own_nxt;
         end
      end
   end
endmodule
